// File: rtl/byte_queue.sv
// byte_queue: single-clock byte FIFO between the USB transaction engine and
// the application. Push/pop strobes are edge-detected so a held strobe moves
// exactly one byte. data_out is registered and holds the last popped byte.
module byte_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                       clk48mhz,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       w_clk,
  input  logic                       r_clk,
  output logic [WIDTH-1:0]           data_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Storage array: no reset so it maps onto distributed or block RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  logic             w_q, w_d;
  logic             r_q, r_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;

  logic push_req, pop_req;
  logic push_ok, pop_ok;

  // Flags come straight from the registered count: no strobe-to-flag path.
  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign level    = level_q;
  assign data_out = data_out_q;

  // Edge detect and acceptance; both judged against pre-edge flags, and
  // reset blocks the memory write so it wins over a concurrent push.
  always_comb begin
    push_req = w_clk & ~w_q;
    pop_req  = r_clk & ~r_q;
    push_ok  = push_req & ~full  & ~rst;
    pop_ok   = pop_req  & ~empty & ~rst;
  end

  // Next-state for pointers, count, output byte and strobe history.
  always_comb begin
    w_d        = w_clk;
    r_d        = r_clk;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    data_out_d = data_out_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      data_out_d = mem[rd_ptr_q];
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk48mhz) begin
    if (rst) begin
      w_q        <= 1'b0;
      r_q        <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      data_out_q <= '0;
    end else begin
      w_q        <= w_d;
      r_q        <= r_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      data_out_q <= data_out_d;
    end
  end

  // Single synchronous write port.
  always_ff @(posedge clk48mhz) begin
    if (push_ok) mem[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_byte_queue.sv
// Self-checking bench for byte_queue: directed scenarios followed by random
// strobes, every cycle compared against a queue-based reference model.
module tb_byte_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;

  logic             clk48mhz = 1'b0;
  logic             rst      = 1'b1;
  logic [WIDTH-1:0] data_in  = '0;
  logic             w_clk    = 1'b0;
  logic             r_clk    = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             empty, full;
  logic [$clog2(DEPTH):0] level;

  int checks = 0;
  int errors = 0;

  // Reference model state
  byte unsigned     mq[$];
  logic             m_wp = 1'b0, m_rp = 1'b0;
  logic [WIDTH-1:0] m_dout = '0;

  byte_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk48mhz (clk48mhz),
    .rst      (rst),
    .data_in  (data_in),
    .w_clk    (w_clk),
    .r_clk    (r_clk),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .level    (level)
  );

  always #5 clk48mhz = ~clk48mhz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model of one clock edge: flags sampled before either operation is applied.
  task automatic model_edge();
    bit push, pop, was_empty, was_full;
    if (rst) begin
      mq.delete();
      m_dout = '0;
      m_wp   = 1'b0;
      m_rp   = 1'b0;
    end else begin
      push      = w_clk && !m_wp;
      pop       = r_clk && !m_rp;
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == DEPTH);
      if (pop && !was_empty) m_dout = mq.pop_front();
      if (push && !was_full) mq.push_back(data_in);
      m_wp = w_clk;
      m_rp = r_clk;
    end
  endtask

  task automatic compare();
    chk("level",    32'(level),    32'(mq.size()));
    chk("empty",    32'(empty),    32'(mq.size() == 0));
    chk("full",     32'(full),     32'(mq.size() == DEPTH));
    chk("data_out", 32'(data_out), 32'(m_dout));
  endtask

  // One cycle: drive, clock, update model, sample 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
    w_clk   = w;
    r_clk   = r;
    data_in = d;
    @(posedge clk48mhz);
    model_edge();
    #1;
    compare();
  endtask

  task automatic push_b(input logic [WIDTH-1:0] d);
    step(1'b1, 1'b0, d);
    step(1'b0, 1'b0, d);
  endtask

  task automatic pop_b();
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
  endtask

  task automatic drain();
    while (mq.size() != 0) pop_b();
  endtask

  logic [WIDTH-1:0] saved;
  int pw, pr;

  initial begin
    // Reset then idle
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    rst = 1'b0;
    step(1'b0, 1'b0, '0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_dout",  32'(data_out), 32'd0);
    pop_b();
    chk("pop_empty_dout",  32'(data_out), 32'd0);
    chk("pop_empty_level", 32'(level),    32'd0);

    // Basic ordering and one-cycle read latency
    push_b(8'hA1); push_b(8'hB2); push_b(8'hC3);
    step(1'b0, 1'b1, '0); chk("rd0", 32'(data_out), 32'hA1); step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0); chk("rd1", 32'(data_out), 32'hB2); step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0); chk("rd2", 32'(data_out), 32'hC3); step(1'b0, 1'b0, '0);
    chk("rd_empty", 32'(empty), 32'd1);

    // Held strobe moves one byte
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h55);
    chk("hold_level", 32'(level), 32'd1);
    step(1'b0, 1'b0, 8'h55);
    step(1'b1, 1'b0, 8'h66);
    chk("rehit_level", 32'(level), 32'd2);
    step(1'b0, 1'b0, 8'h66);
    drain();

    // Wrap-around, twice (second pass with pointers offset by 10)
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        for (int i = 0; i < 10; i++) push_b(8'(i + 8'h80));
        drain();
      end
      for (int i = 0; i < DEPTH; i++) push_b(8'(i));
      chk("fill_full", 32'(full), 32'd1);
      push_b(8'hFF);
      chk("over_level", 32'(level), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
        pop_b();
        chk("wrap_order", 32'(data_out), 32'(i));
      end
      chk("wrap_empty", 32'(empty), 32'd1);
    end

    // Simultaneous strobes, mid-level
    push_b(8'h11); push_b(8'h22); push_b(8'h33);
    step(1'b1, 1'b1, 8'h44);
    chk("sim_mid_level", 32'(level),    32'd3);
    chk("sim_mid_dout",  32'(data_out), 32'h11);
    step(1'b0, 1'b0, '0);
    drain();

    // Simultaneous strobes when empty
    saved = data_out;
    step(1'b1, 1'b1, 8'h99);
    chk("sim_empty_level", 32'(level),    32'd1);
    chk("sim_empty_dout",  32'(data_out), 32'(saved));
    step(1'b0, 1'b0, '0);

    // Simultaneous strobes when full
    for (int i = 1; i < DEPTH; i++) push_b(8'(i + 8'h40));
    chk("sim_full_pre", 32'(full), 32'd1);
    step(1'b1, 1'b1, 8'hEE);
    chk("sim_full_level", 32'(level),    32'(DEPTH - 1));
    chk("sim_full_dout",  32'(data_out), 32'h99);
    step(1'b0, 1'b0, '0);
    drain();
    chk("sim_full_no_ee", 32'(data_out), 32'(8'h40 + DEPTH - 1));

    // Mid-operation reset with write strobe held high
    for (int i = 0; i < 5; i++) push_b(8'(i + 8'h20));
    chk("pre_rst_level", 32'(level), 32'd5);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h77);
    step(1'b1, 1'b0, 8'h77);
    chk("mid_rst_empty", 32'(empty),    32'd1);
    chk("mid_rst_dout",  32'(data_out), 32'd0);
    rst = 1'b0;
    step(1'b1, 1'b0, 8'h77);
    chk("post_rst_level", 32'(level), 32'd1);
    step(1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b0, '0);
    pop_b();
    chk("post_rst_dout", 32'(data_out), 32'h77);

    // Random strobes with drifting push/pop bias to reach both flags
    for (int c = 0; c < 4000; c++) begin
      pw = ((c / 500) % 2 == 0) ? 70 : 30;
      pr = 100 - pw;
      rst = ($urandom_range(0, 299) == 0);
      step(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), 8'($urandom));
    end
    rst = 1'b0;
    step(1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
